// File: rtl/timer_irq_gen.sv
// Machine-timer interrupt source: 64-bit mtime/mtimecmp pair plus CTRL.EN on a word bus.
// Optional build macro TIMER_PRESCALER_EN divides the mtime tick rate by PRESCALE.
module timer_irq_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        time_interupt
);

    // Bus access: wr_en/rd_en are single-cycle full-word strobes with no stall;
    // a write commits on the clock edge ending the strobe cycle, a read is combinational.
    localparam logic [2:0] SEL_MTIME_LO = 3'd0;
    localparam logic [2:0] SEL_MTIME_HI = 3'd1;
    localparam logic [2:0] SEL_CMP_LO   = 3'd2;
    localparam logic [2:0] SEL_CMP_HI   = 3'd3;
    localparam logic [2:0] SEL_CTRL     = 3'd4;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        en;

    logic        hit;
    logic [2:0]  sel;
    logic        wr_hit;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        wr_ctrl_clr;
    logic        tick;
    logic        inc;
    logic        unused_addr_bits;

    assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
    assign sel              = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];

    assign wr_hit      = wr_en & hit;
    assign wr_mtime_lo = wr_hit & (sel == SEL_MTIME_LO);
    assign wr_mtime_hi = wr_hit & (sel == SEL_MTIME_HI);
    assign wr_cmp_lo   = wr_hit & (sel == SEL_CMP_LO);
    assign wr_cmp_hi   = wr_hit & (sel == SEL_CMP_HI);
    assign wr_ctrl     = wr_hit & (sel == SEL_CTRL);
    assign wr_ctrl_clr = wr_ctrl & ~wdata[0];

`ifdef TIMER_PRESCALER_EN
    localparam logic [15:0] PRESCALE_TOP = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt;

    assign tick = en & (pre_cnt == PRESCALE_TOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= 16'd0;
        end else if (!en || wr_mtime_lo || wr_mtime_hi || wr_ctrl_clr || tick) begin
            pre_cnt <= 16'd0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end
`else
    assign tick = en;
`endif

    // Any mtime write, or disabling in this cycle, suppresses the pending increment.
    assign inc = tick & ~wr_mtime_lo & ~wr_mtime_hi & ~wr_ctrl_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= wdata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= wdata;
        end else if (inc) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= wdata;
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= 1'b0;
        end else if (wr_ctrl) begin
            en <= wdata[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_interupt <= 1'b0;
        end else begin
            time_interupt <= en & (mtime >= mtimecmp);
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (rd_en && hit) begin
            case (sel)
                SEL_MTIME_LO: rdata = mtime[31:0];
                SEL_MTIME_HI: rdata = mtime[63:32];
                SEL_CMP_LO:   rdata = mtimecmp[31:0];
                SEL_CMP_HI:   rdata = mtimecmp[63:32];
                SEL_CTRL:     rdata = {31'd0, en};
                default:      rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_gen.sv
// Directed bench for timer_irq_gen: expected values queued as stimulus is applied,
// popped and checked against rdata / time_interupt at negedge sample points.
module tb_timer_irq_gen;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        time_interupt;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

`ifdef TIMER_PRESCALER_EN
    timer_irq_gen #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
`else
    timer_irq_gen #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
`endif
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .time_interupt(time_interupt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input logic [31:0] v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow: observed %h expected <none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            vectors++;
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    // Called just after a negedge; the posedge in the middle commits the write.
    task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
        addr  = BASE + off;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string tag);
        expect_val(e, tag);
        addr  = a;
        rd_en = 1'b1;
        #1;
        compare(rdata);
        rd_en = 1'b0;
    endtask

    task automatic check_irq(input logic e, input string tag);
        expect_val({31'd0, e}, tag);
        compare({31'd0, time_interupt});
    endtask

    initial begin
        rst   = 1'b1;
        addr  = 32'h0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 32'h0;
        @(negedge clk);

        bus_read(BASE + 32'h00, 32'h0000_0000, "rst_mtime_lo");
        bus_read(BASE + 32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        bus_read(BASE + 32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        bus_read(BASE + 32'h10, 32'h0000_0000, "rst_ctrl");
        check_irq(1'b0, "rst_irq");
        rst = 1'b0;
        @(negedge clk);

`ifndef TIMER_PRESCALER_EN
        bus_write(32'h0C, 32'h0);
        bus_write(32'h08, 32'd10);
        bus_write(32'h10, 32'h1);
        cyc(10);
        bus_read(BASE + 32'h00, 32'd10, "count_to_cmp");
        check_irq(1'b0, "irq_not_early");
        cyc(1);
        check_irq(1'b1, "irq_rise");
        bus_read(BASE + 32'h00, 32'd11, "count_past_cmp");

        bus_write(32'h08, 32'd1000);
        check_irq(1'b1, "irq_cmp_write_edge");
        cyc(1);
        check_irq(1'b0, "irq_cmp_rewrite_drop");

        bus_write(32'h08, 32'd10);
        cyc(1);
        check_irq(1'b1, "irq_reassert");
        bus_write(32'h10, 32'h0);
        check_irq(1'b1, "irq_ctrl_write_edge");
        cyc(1);
        check_irq(1'b0, "irq_ctrl_clear_drop");
        bus_read(BASE + 32'h00, 32'd15, "freeze_a");
        cyc(5);
        bus_read(BASE + 32'h00, 32'd15, "freeze_b");

        bus_write(32'h10, 32'h1);
        bus_write(32'h00, 32'hFFFF_FFFF);
        bus_write(32'h04, 32'h0);
        bus_read(BASE + 32'h00, 32'hFFFF_FFFF, "hi_write_no_inc");
        cyc(1);
        bus_read(BASE + 32'h00, 32'h0, "carry_lo");
        bus_read(BASE + 32'h04, 32'h1, "carry_hi");

        bus_write(32'h00, 32'hFFFF_FFFF);
        bus_write(32'h04, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h04, 32'hFFFF_FFFF, "all_ones_hi");
        cyc(1);
        bus_read(BASE + 32'h00, 32'h0, "wrap_lo");
        bus_read(BASE + 32'h04, 32'h0, "wrap_hi");

        bus_write(32'h00, 32'd50);
        bus_read(BASE + 32'h00, 32'd50, "write_beats_tick");
        cyc(1);
        bus_read(BASE + 32'h00, 32'd51, "count_resumes");

        bus_read(BASE + 32'h18, 32'h0, "reserved_read");
        bus_read(32'h0300_0000, 32'h0, "base_miss");
        bus_read(BASE + 32'h11, 32'h1, "byte_offset_ignored");
        expect_val(32'h0, "rd_en_low");
        addr = BASE + 32'h08;
        #1;
        compare(rdata);

        cyc(1);
        addr  = BASE + 32'h08;
        wdata = 32'd77;
        wr_en = 1'b1;
        expect_val(32'd10, "read_during_write");
        rd_en = 1'b1;
        #1;
        compare(rdata);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        bus_read(BASE + 32'h08, 32'd77, "cmp_lo_written");
        bus_read(BASE + 32'h0C, 32'h0, "cmp_hi_untouched");
`else
        bus_write(32'h0C, 32'h0);
        bus_write(32'h08, 32'd2);
        bus_write(32'h10, 32'h1);
        cyc(8);
        bus_read(BASE + 32'h00, 32'd2, "pre_mtime_2");
        check_irq(1'b0, "pre_irq_not_early");
        cyc(1);
        check_irq(1'b1, "pre_irq_rise");
        cyc(3);
        bus_read(BASE + 32'h00, 32'd3, "pre_mtime_3");
        bus_write(32'h00, 32'h0);
        cyc(3);
        bus_read(BASE + 32'h00, 32'd0, "pre_restart_hold");
        cyc(1);
        bus_read(BASE + 32'h00, 32'd1, "pre_restart_tick");
`endif

        cyc(1);
        #2;
        rst = 1'b1;
        bus_read(BASE + 32'h00, 32'h0, "async_rst_mtime");
        bus_read(BASE + 32'h08, 32'hFFFF_FFFF, "async_rst_cmp");
        check_irq(1'b0, "async_rst_irq");
        @(negedge clk);
        rst = 1'b0;
        cyc(3);
        bus_read(BASE + 32'h00, 32'h0, "post_rst_no_count");
        bus_read(BASE + 32'h10, 32'h0, "post_rst_ctrl");
        check_irq(1'b0, "post_rst_irq");

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
